// File: rtl/grey_window_gen_pkg.sv
// Shared window geometry and tap indexing for the grey 3x3 window generator.
package grey_win_pkg;
  localparam int WIN_K     = 3;
  localparam int WIN_TAPS  = 9;
  localparam int PIX_W_DEF = 8;

  function automatic int win_idx(input int r, input int c);
    return WIN_K * r + c;
  endfunction
endpackage

// File: rtl/grey_line_ram.sv
// One image line of pixels: asynchronous read, synchronous write-enable, contents not reset.
module grey_line_ram #(
  parameter  int DEPTH = 512,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/grey_window_gen.sv
// 3x3 window generator over two line buffers, 1-cycle registered output; input ready drops only
// while a window is held unconsumed. Defining WIN_SIDEBAND_EN adds o_window_sof/o_window_eol.
module grey_window_gen
  import grey_win_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int PIX_W      = PIX_W_DEF
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic                      i_grey_data_valid,
  input  logic [PIX_W-1:0]          i_grey_data,
  output logic                      o_grey_data_ready,
  output logic                      o_window_valid,
  output logic [WIN_TAPS*PIX_W-1:0] o_window_data,
  input  logic                      i_window_ready
`ifdef WIN_SIDEBAND_EN
  ,
  output logic                      o_window_sof,
  output logic                      o_window_eol
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // One window column, index 0 = top row, index WIN_K-1 = current row.
  typedef logic [WIN_K-1:0][PIX_W-1:0] col_t;

  logic [CW-1:0]             r_col;
  logic [RW-1:0]             r_row;
  col_t                      r_sh0;
  col_t                      r_sh1;
  logic                      r_win_vld;
  logic [WIN_TAPS*PIX_W-1:0] r_win_dat;

  logic                      w_accept;
  logic                      w_is_win;
  logic [PIX_W-1:0]          w_top;
  logic [PIX_W-1:0]          w_mid;
  col_t                      w_new;
  logic [WIN_TAPS*PIX_W-1:0] w_win;

  assign o_grey_data_ready = !(r_win_vld && !i_window_ready);
  assign w_accept          = i_grey_data_valid && o_grey_data_ready;
  assign w_is_win          = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_new             = {i_grey_data, w_mid, w_top};
  assign o_window_valid    = r_win_vld;
  assign o_window_data     = r_win_dat;

  grey_line_ram #(.DEPTH(IMG_WIDTH), .W(PIX_W)) lb0 (
    .i_clk  (axi_clk),
    .i_we   (w_accept),
    .i_addr (r_col),
    .i_wdata(w_mid),
    .o_rdata(w_top)
  );

  grey_line_ram #(.DEPTH(IMG_WIDTH), .W(PIX_W)) lb1 (
    .i_clk  (axi_clk),
    .i_we   (w_accept),
    .i_addr (r_col),
    .i_wdata(i_grey_data),
    .o_rdata(w_mid)
  );

  always_comb begin
    w_win = '0;
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K; c++) begin
        if (c == 0)      w_win[PIX_W*win_idx(r, c) +: PIX_W] = r_sh0[r];
        else if (c == 1) w_win[PIX_W*win_idx(r, c) +: PIX_W] = r_sh1[r];
        else             w_win[PIX_W*win_idx(r, c) +: PIX_W] = w_new[r];
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_col <= '0;
      r_row <= '0;
      r_sh0 <= '0;
      r_sh1 <= '0;
    end else if (w_accept) begin
      r_sh0 <= r_sh1;
      r_sh1 <= w_new;
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // An accept always retires the pending window, so the new one replaces it without a bubble.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_win_vld <= 1'b0;
      r_win_dat <= '0;
    end else if (w_accept) begin
      r_win_vld <= w_is_win;
      if (w_is_win) r_win_dat <= w_win;
    end else if (i_window_ready) begin
      r_win_vld <= 1'b0;
    end
  end

`ifdef WIN_SIDEBAND_EN
  logic r_sof;
  logic r_eol;

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      r_sof <= 1'b0;
      r_eol <= 1'b0;
    end else if (w_accept && w_is_win) begin
      r_sof <= (r_row == RW'(2)) && (r_col == CW'(2));
      r_eol <= (r_col == COL_LAST);
    end
  end

  assign o_window_sof = r_sof;
  assign o_window_eol = r_eol;
`endif
endmodule

// File: doc/grey_window_gen.md
Name: grey_window_gen

Overview:
Streaming 3x3 neighbourhood generator placed directly downstream of rgb2grey. It consumes the 8-bit greyscale pixel stream in raster order and buffers two previous image lines. It emits one 72-bit 3x3 window per accepted pixel once a full neighbourhood exists. Its output feeds the convolution/filter stages.

Parameters:
IMG_WIDTH, 512, pixels per line (>=3)
IMG_HEIGHT, 512, lines per frame (>=3)
PIX_W, 8, bits per grey pixel

Ports:
axi_clk  in  1  system clock, all logic on rising edge
axi_reset  in  1  asynchronous, active-high reset
i_grey_data_valid  in  1  input pixel valid
i_grey_data  in  PIX_W  grey pixel, raster order
o_grey_data_ready  out  1  block can accept a pixel this cycle
o_window_valid  out  1  o_window_data holds a valid window
o_window_data  out  9*PIX_W  3x3 window, packing below
i_window_ready  in  1  downstream accepts window

Behaviour:
- Clocking/reset: one clock (axi_clk); axi_reset is asynchronous, active-high.
- Reset values: o_window_valid=0, o_window_data=0, col=0, row=0, window shift registers=0. Line RAM contents are not reset (don't-care).
- Accept: a pixel is accepted when i_grey_data_valid && o_grey_data_ready.
- Ready: o_grey_data_ready = !(o_window_valid && !i_window_ready). The ready path is combinational; there is no skid buffer.
- Stall: while o_window_valid=1 and i_window_ready=0, o_window_data and all internal state are held.
- Line buffers on accept at column col:
  - top_tap = lb0[col], mid_tap = lb1[col].
  - Write lb0[col] <= lb1[col] and lb1[col] <= pixel.
  - Shift columns into the 3x3 register: new column = {top_tap, mid_tap, pixel}.
- Counters: col increments 0..IMG_WIDTH-1. At wrap, col returns to 0 and row increments. At the last pixel of the frame, row wraps to 0 and the next frame starts with no gap cycles.
- Output: registered, 1-cycle latency. On the accept of a pixel with row>=2 && col>=2, the next cycle shows o_window_valid=1.
  - If that pixel does not complete a window and the current window is consumed (or none is pending), o_window_valid clears.
  - Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). There is no border padding.
- Packing: o_window_data[PIX_W*(3r+c) +: PIX_W] = pixel at (row-2+r, col-2+c), for r,c in 0..2.
  - Bits [7:0] hold the top-left pixel.
  - Bits [71:64] hold the newest pixel.
- Simultaneous consume and accept: the new window replaces the old one in the same edge with no bubble, giving 1 window/cycle at full rate.
- Reset mid-frame: counters restart at (0,0). Stale RAM data is never emitted, because windows are gated by row>=2.
- Widths: col is $clog2(IMG_WIDTH) bits and row is $clog2(IMG_HEIGHT) bits. No arithmetic is done on pixel values.

Optional Feature:
Macro WIN_SIDEBAND_EN. When defined, two extra outputs are added, both reset to 0 and held under stall:
- o_window_sof (1 bit): high with the first window of a frame (row=2, col=2).
- o_window_eol (1 bit): high with the last window of each line (col=IMG_WIDTH-1).

When the macro is not defined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package grey_win_pkg holds:
  - localparams WIN_K=3 and WIN_TAPS=9;
  - the function win_idx(r,c) returning 3*r+c;
  - a shared PIX_W default.
- One sub-module, grey_line_ram: an IMG_WIDTH x PIX_W single-port line buffer with asynchronous read and synchronous write-enable. It is instantiated twice (lb0, lb1).
- Counters, the shift registers and the handshake logic stay in the top module.

Test Plan:
1. Basic window: IMG_WIDTH=4, IMG_HEIGHT=4, pixels 0..15 streamed with valid always 1 and i_window_ready=1.
   - Exactly 4 windows appear.
   - First window appears the cycle after pixel 10 is accepted, with bytes {0,1,2,4,5,6,8,9,10} from [7:0] upward.
   - Last window is {5,6,7,9,10,11,13,14,15}.
2. Backpressure: same stream with i_window_ready=0 for 5 cycles while the first window is pending.
   - o_grey_data_ready=0 and o_window_data is stable during the stall.
   - No pixel is lost; the sequence of 4 windows is identical to case 1.
3. Back-to-back frames: two 4x4 frames, pixels 0..15 then 100..115, no gap.
   - 8 windows total.
   - The 5th window is {100,101,102,104,105,106,108,109,110}.
   - No window mixes pixels of the two frames.
4. Reset mid-frame: assert axi_reset asynchronously after pixel 9, then restart with pixels 0..15.
   - Outputs go to 0 immediately on assertion.
   - Exactly 4 correct windows follow, same as case 1.
5. Full size chained after rgb2grey: 512x512 grey stream.
   - 510*510 = 260100 windows.
   - The window count matches a software model and the bench checks every window byte-exact.
6. With WIN_SIDEBAND_EN defined: 4x4 ramp.
   - o_window_sof is high only on the first window.
   - o_window_eol is high on windows 2 and 4.
